// File: rtl/br_ram_flops_1r1w_rd_arb_pkg.sv
// Shared types and helpers for the flop-RAM read-port arbiter.
package br_ram_flops_1r1w_rd_arb_pkg;

  typedef enum logic {
    StateInit   = 1'b0,
    StateActive = 1'b1
  } state_e;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/br_ram_flops_1r1w_rd_arb_arb_rr.sv
// Round-robin arbiter: priority starts just after the last granted requester.
module br_arb_rr
  import br_ram_flops_1r1w_rd_arb_pkg::*;
#(
  parameter int NumRequesters = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [NumRequesters-1:0] i_req,
  output logic [NumRequesters-1:0] o_grant
);

  localparam int IdxWidth = addr_width(NumRequesters);

  logic [IdxWidth-1:0] r_last;
  logic [IdxWidth-1:0] w_grant_idx;
  logic [IdxWidth-1:0] w_cand;
  int                  w_idx;

  // Walk from the farthest to the nearest candidate so the nearest valid one wins.
  always_comb begin
    o_grant     = '0;
    w_grant_idx = r_last;
    w_idx       = 0;
    w_cand      = '0;
    for (int off = NumRequesters; off >= 1; off--) begin
      w_idx  = (int'(r_last) + off) % NumRequesters;
      w_cand = w_idx[IdxWidth-1:0];
      if (i_en && i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        w_grant_idx     = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IdxWidth'(NumRequesters - 1);
    end else if (|o_grant) begin
      r_last <= w_grant_idx;
    end
  end

endmodule

// File: rtl/br_ram_flops_1r1w_rd_arb.sv
// Shares the read port of a 1R1W flop RAM among clients and owns its write port.
// Define BR_RAM_FLOPS_1R1W_RD_ARB_INIT_EN to clear the RAM with InitValue after reset.
//   state       | meaning
//   StateInit   | sweeping InitValue into every entry, no reads or upstream writes
//   StateActive | reads arbitrated, upstream writes passed through
module br_ram_flops_1r1w_rd_arb
  import br_ram_flops_1r1w_rd_arb_pkg::*;
#(
  parameter int               NumRequesters = 4,
  parameter int               Depth         = 16,
  parameter int               Width         = 8,
  parameter int               ReadLatency   = 0,
  parameter logic [Width-1:0] InitValue     = '0,
  localparam int              AddrWidth     = addr_width(Depth)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumRequesters-1:0]           i_rd_req_valid,
  output logic [NumRequesters-1:0]           o_rd_req_ready,
  input  logic [NumRequesters*AddrWidth-1:0] i_rd_req_addr,
  output logic [NumRequesters-1:0]           o_rd_resp_valid,
  output logic [Width-1:0]                   o_rd_resp_data,
  input  logic                               i_wr_valid,
  output logic                               o_wr_ready,
  input  logic [AddrWidth-1:0]               i_wr_addr,
  input  logic [Width-1:0]                   i_wr_data,
  output logic                               o_ram_wr_valid,
  output logic [AddrWidth-1:0]               o_ram_wr_addr,
  output logic [Width-1:0]                   o_ram_wr_data,
  output logic                               o_ram_rd_addr_valid,
  output logic [AddrWidth-1:0]               o_ram_rd_addr,
  input  logic                               i_ram_rd_data_valid,
  input  logic [Width-1:0]                   i_ram_rd_data,
  output logic                               o_init_done
);

  if (NumRequesters < 2) begin : g_bad_nreq
    $error("NumRequesters must be at least 2");
  end
  if (Depth < 2) begin : g_bad_depth
    $error("Depth must be at least 2");
  end
  if (Width < 1) begin : g_bad_width
    $error("Width must be at least 1");
  end
  if (ReadLatency < 0) begin : g_bad_lat
    $error("ReadLatency must not be negative");
  end

  state_e                   r_state;
  logic                     r_init_done;
  logic                     w_active;
  logic                     w_init_wr;
  logic [AddrWidth-1:0]     w_init_addr;
  logic [Width-1:0]         w_init_data;
  logic [NumRequesters-1:0] w_grant;
  logic [NumRequesters-1:0] w_tag_out;

`ifdef BR_RAM_FLOPS_1R1W_RD_ARB_INIT_EN
  logic [AddrWidth-1:0] r_init_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StateInit;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == StateInit) begin
      r_init_addr <= r_init_addr + 1'b1;
      if (r_init_addr == AddrWidth'(Depth - 1)) begin
        r_state     <= StateActive;
        r_init_done <= 1'b1;
      end
    end
  end

  assign w_init_wr   = (r_state == StateInit) && !rst;
  assign w_init_addr = r_init_addr;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StateActive;
      r_init_done <= 1'b1;
    end
  end

  assign w_init_wr   = 1'b0;
  assign w_init_addr = '0;
`endif

  assign w_init_data = InitValue;
  assign w_active    = (r_state == StateActive) && !rst;
  assign o_wr_ready  = (r_state == StateActive);
  assign o_init_done = r_init_done;

  always_comb begin
    o_ram_wr_valid = 1'b0;
    o_ram_wr_addr  = i_wr_addr;
    o_ram_wr_data  = i_wr_data;
    if (w_init_wr) begin
      o_ram_wr_valid = 1'b1;
      o_ram_wr_addr  = w_init_addr;
      o_ram_wr_data  = w_init_data;
    end else if (w_active) begin
      o_ram_wr_valid = i_wr_valid;
    end
  end

  br_arb_rr #(
    .NumRequesters(NumRequesters)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_active),
    .i_req  (i_rd_req_valid),
    .o_grant(w_grant)
  );

  assign o_rd_req_ready      = w_grant;
  assign o_ram_rd_addr_valid = |w_grant;

  always_comb begin
    o_ram_rd_addr = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (w_grant[i]) o_ram_rd_addr = i_rd_req_addr[i*AddrWidth +: AddrWidth];
    end
  end

  // The grant rides alongside the RAM read so the data finds its way back to the issuer.
  if (ReadLatency == 0) begin : g_tag_comb
    assign w_tag_out = w_grant;
  end else begin : g_tag_pipe
    logic [NumRequesters-1:0] r_tag [ReadLatency];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < ReadLatency; i++) r_tag[i] <= '0;
      end else begin
        r_tag[0] <= w_grant;
        for (int i = 1; i < ReadLatency; i++) r_tag[i] <= r_tag[i-1];
      end
    end

    assign w_tag_out = r_tag[ReadLatency-1];
  end

  assign o_rd_resp_valid = w_tag_out & {NumRequesters{i_ram_rd_data_valid && !rst}};
  assign o_rd_resp_data  = i_ram_rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(w_grant))
        else $error("read grant is not one-hot");
      assert (i_ram_rd_data_valid == (|w_tag_out))
        else $error("RAM read data valid disagrees with issued tag");
      assert (!((r_state == StateInit) && (|w_grant)))
        else $error("read granted during init sweep");
    end
  end

endmodule

// File: tb/tb_br_ram_flops_1r1w_rd_arb.sv
// Randomized and directed bench for br_ram_flops_1r1w_rd_arb with a two-cycle flop RAM model.
module tb_br_ram_flops_1r1w_rd_arb;

  localparam int N   = 4;
  localparam int D   = 16;
  localparam int W   = 8;
  localparam int AW  = 4;
  localparam int LAT = 2;
`ifdef BR_RAM_FLOPS_1R1W_RD_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    rd_req_valid;
  logic [N-1:0]    rd_req_ready;
  logic [N*AW-1:0] rd_req_addr;
  logic [N-1:0]    rd_resp_valid;
  logic [W-1:0]    rd_resp_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            ram_wr_valid;
  logic [AW-1:0]   ram_wr_addr;
  logic [W-1:0]    ram_wr_data;
  logic            ram_rd_addr_valid;
  logic [AW-1:0]   ram_rd_addr;
  logic            ram_rd_data_valid;
  logic [W-1:0]    ram_rd_data;
  logic            init_done;

  br_ram_flops_1r1w_rd_arb #(
    .NumRequesters(N),
    .Depth        (D),
    .Width        (W),
    .ReadLatency  (LAT),
    .InitValue    (8'h00)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_rd_req_valid     (rd_req_valid),
    .o_rd_req_ready     (rd_req_ready),
    .i_rd_req_addr      (rd_req_addr),
    .o_rd_resp_valid    (rd_resp_valid),
    .o_rd_resp_data     (rd_resp_data),
    .i_wr_valid         (wr_valid),
    .o_wr_ready         (wr_ready),
    .i_wr_addr          (wr_addr),
    .i_wr_data          (wr_data),
    .o_ram_wr_valid     (ram_wr_valid),
    .o_ram_wr_addr      (ram_wr_addr),
    .o_ram_wr_data      (ram_wr_data),
    .o_ram_rd_addr_valid(ram_rd_addr_valid),
    .o_ram_rd_addr      (ram_rd_addr),
    .i_ram_rd_data_valid(ram_rd_data_valid),
    .i_ram_rd_data      (ram_rd_data),
    .o_init_done        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flop RAM: read sees contents before a same-cycle write, data two cycles later.
  logic [W-1:0] mem [D];
  logic [W-1:0] rd_d0, rd_d1;
  logic         rd_v0, rd_v1;

  always @(posedge clk) begin
    if (ram_wr_valid) mem[ram_wr_addr] <= ram_wr_data;
    rd_d0 <= mem[ram_rd_addr];
    rd_d1 <= rd_d0;
    if (rst) begin
      rd_v0 <= 1'b0;
      rd_v1 <= 1'b0;
    end else begin
      rd_v0 <= ram_rd_addr_valid;
      rd_v1 <= rd_v0;
    end
  end

  assign ram_rd_data_valid = rd_v1;
  assign ram_rd_data       = rd_d1;

  // Reference model state.
  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int last_g = N - 1;
  bit model_active = 1'b0;
  logic [W-1:0] shadow [D];

  typedef struct {
    int           due;
    logic [N-1:0] who;
    logic [W-1:0] data;
  } resp_t;
  resp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic step();
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [W-1:0]  ed;
    logic [AW-1:0] ga;
    int            gi;
    bit            act;
    #1;
    act = model_active && !rst;
    eg  = '0;
    erv = '0;
    ed  = '0;
    ga  = '0;
    gi  = -1;
    if (act) begin
      for (int off = 1; off <= N; off++) begin
        int idx;
        idx = (last_g + off) % N;
        if (gi < 0 && rd_req_valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ga     = rd_req_addr[gi*AW +: AW];
    end
    chk("rd_req_ready", rd_req_ready, eg);
    chk("ram_rd_addr_valid", ram_rd_addr_valid, gi >= 0);
    if (gi >= 0) chk("ram_rd_addr", ram_rd_addr, ga);
    if (q.size() > 0 && q[0].due == cyc_n) begin
      erv = q[0].who;
      ed  = q[0].data;
      void'(q.pop_front());
    end
    chk("rd_resp_valid", rd_resp_valid, erv);
    if (erv != '0) chk("rd_resp_data", rd_resp_data, ed);
    if (act) begin
      chk("wr_ready", wr_ready, 1);
      chk("init_done", init_done, 1);
      chk("ram_wr_valid", ram_wr_valid, wr_valid);
      if (wr_valid) begin
        chk("ram_wr_addr", ram_wr_addr, wr_addr);
        chk("ram_wr_data", ram_wr_data, wr_data);
      end
    end
    if (gi >= 0) begin
      q.push_back('{cyc_n + LAT, eg, shadow[ga]});
      last_g = gi;
    end
    if (act && wr_valid) shadow[wr_addr] = wr_data;
    tick();
  endtask

  task automatic idle(input int n);
    rd_req_valid = '0;
    wr_valid     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    rd_req_valid = '1;
    wr_valid     = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (i > 0) begin
        chk("rst_rd_req_ready", rd_req_ready, 0);
        chk("rst_rd_resp_valid", rd_resp_valid, 0);
        chk("rst_ram_wr_valid", ram_wr_valid, 0);
        chk("rst_ram_rd_addr_valid", ram_rd_addr_valid, 0);
        chk("rst_wr_ready", wr_ready, !INIT_EN);
      end
      tick();
    end
    q.delete();
    last_g       = N - 1;
    model_active = !INIT_EN;
    rst          = 1'b0;
  endtask

`ifdef BR_RAM_FLOPS_1R1W_RD_ARB_INIT_EN
  task automatic init_sweep();
    rd_req_valid = '1;
    wr_valid     = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      chk("init_ram_wr_valid", ram_wr_valid, 1);
      chk("init_ram_wr_addr", ram_wr_addr, i);
      chk("init_ram_wr_data", ram_wr_data, 0);
      chk("init_done_low", init_done, 0);
      chk("init_wr_ready", wr_ready, 0);
      chk("init_rd_req_ready", rd_req_ready, 0);
      chk("init_rd_resp_valid", rd_resp_valid, 0);
      shadow[i] = '0;
      tick();
    end
    #1;
    chk("init_done_rise", init_done, 1);
    chk("init_wr_ready_rise", wr_ready, 1);
    rd_req_valid = '0;
    wr_valid     = 1'b0;
    model_active = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [N-1:0] exp_g;
    rst          = 1'b1;
    rd_req_valid = '0;
    rd_req_addr  = '0;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    @(negedge clk);
    do_reset(3);

`ifdef BR_RAM_FLOPS_1R1W_RD_ARB_INIT_EN
    init_sweep();
    for (int a = 0; a < D; a++) begin
      rd_req_valid          = '0;
      rd_req_valid[a % N]   = 1'b1;
      rd_req_addr           = '0;
      rd_req_addr[(a % N)*AW +: AW] = 4'(a);
      step();
    end
    idle(LAT + 1);
`else
    rd_req_valid              = 4'b1000;
    rd_req_addr[3*AW +: AW]   = 4'd7;
    step();
    idle(LAT + 1);
`endif

    for (int a = 0; a < D; a++) begin
      wr_valid = 1'b1;
      wr_addr  = 4'(a);
      wr_data  = 8'($urandom);
      step();
    end
    wr_addr = 4'd3; wr_data = 8'h11; step();
    wr_addr = 4'd5; wr_data = 8'hA5; step();
    wr_valid = 1'b0;

    // All clients requesting: grants rotate one per cycle.
    rd_req_valid = '1;
    start = (last_g + 1) % N;
    for (int k = 0; k < 8; k++) begin
      rd_req_addr = 16'($urandom);
      exp_g = '0;
      exp_g[(start + k) % N] = 1'b1;
      #1;
      chk("rr_grant", rd_req_ready, exp_g);
      step();
    end
    idle(LAT + 1);

    rd_req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      rd_req_addr = 16'($urandom);
      step();
    end
    idle(LAT + 1);

    rd_req_valid            = 4'b0100;
    rd_req_addr[2*AW +: AW] = 4'd5;
    step();
    rd_req_valid = '0;
    step();
    #1;
    chk("lat_resp_valid", rd_resp_valid, 4'b0100);
    chk("lat_resp_data", rd_resp_data, 8'hA5);
    step();
    idle(1);

    wr_valid                = 1'b1;
    wr_addr                 = 4'd3;
    wr_data                 = 8'h3C;
    rd_req_valid            = 4'b0010;
    rd_req_addr[1*AW +: AW] = 4'd3;
    step();
    wr_valid = 1'b0;
    step();
    rd_req_valid = '0;
    #1;
    chk("col_old_valid", rd_resp_valid, 4'b0010);
    chk("col_old_data", rd_resp_data, 8'h11);
    step();
    #1;
    chk("col_new_valid", rd_resp_valid, 4'b0010);
    chk("col_new_data", rd_resp_data, 8'h3C);
    step();
    idle(1);

    for (int k = 0; k < 300; k++) begin
      rd_req_valid = 4'($urandom);
      rd_req_addr  = 16'($urandom);
      wr_valid     = 1'($urandom);
      wr_addr      = 4'($urandom);
      wr_data      = 8'($urandom);
      step();
    end
    idle(LAT + 1);

    // Reset one cycle after issue: the response must never appear.
    rd_req_valid          = 4'b0001;
    rd_req_addr[0 +: AW]  = 4'd9;
    step();
    do_reset(1);
`ifdef BR_RAM_FLOPS_1R1W_RD_ARB_INIT_EN
    init_sweep();
`endif
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
